// File: rtl/exu_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer around the combinational EXU.
// Optional performance counters are enabled with `define EXU_SEQ_PERF_CNT_EN.
module exu_seq_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned           TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  input  logic                  ifu_rsp_valid,
  input  logic [31:0]           ifu_inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [31:0]           inst,
  input  logic                  idu_illegal,
  input  logic                  idu_ebreak,
  input  logic                  exu_wen,
  input  logic [4:0]            exu_waddr,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic                  rf_wen,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  halt,
  output logic [1:0]            halt_code,
`ifdef EXU_SEQ_PERF_CNT_EN
  output logic [63:0]           perf_cycle,
  output logic [63:0]           perf_retire,
`endif
  output logic                  busy
);

  localparam int unsigned           CntWidth = $clog2(TIMEOUT + 1);
  localparam logic [CntWidth-1:0]   CntMax   = CntWidth'(TIMEOUT);

  localparam logic [2:0] StBoot      = 3'd0;
  localparam logic [2:0] StFetchReq  = 3'd1;
  localparam logic [2:0] StFetchWait = 3'd2;
  localparam logic [2:0] StDecode    = 3'd3;
  localparam logic [2:0] StExec      = 3'd4;
  localparam logic [2:0] StWb        = 3'd5;
  localparam logic [2:0] StHalt      = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] next_pc_q, next_pc_d;
  logic [31:0]           inst_q, inst_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  wb_wen_q, wb_wen_d;
  logic [4:0]            wb_waddr_q, wb_waddr_d;
  logic [DATA_WIDTH-1:0] wb_wdata_q, wb_wdata_d;
  logic [1:0]            halt_code_q, halt_code_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    next_pc_d   = next_pc_q;
    inst_d      = inst_q;
    cnt_d       = cnt_q;
    wb_wen_d    = wb_wen_q;
    wb_waddr_d  = wb_waddr_q;
    wb_wdata_d  = wb_wdata_q;
    halt_code_d = halt_code_q;
    case (state_q)
      StBoot:     state_d = StFetchReq;
      StFetchReq: if (ifu_req_ready) state_d = StFetchWait;
      StFetchWait: begin
        // A response on the final counter cycle still wins over the timeout.
        if (ifu_rsp_valid) begin
          inst_d  = ifu_inst;
          cnt_d   = '0;
          state_d = StDecode;
        end else if (cnt_q == CntMax) begin
          halt_code_d = 2'd3;
          state_d     = StHalt;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDecode: begin
        if (idu_illegal) begin
          halt_code_d = 2'd2;
          state_d     = StHalt;
        end else if (idu_ebreak) begin
          halt_code_d = 2'd1;
          state_d     = StHalt;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        wb_wen_d   = exu_wen & (exu_waddr != 5'd0);
        wb_waddr_d = exu_waddr;
        wb_wdata_d = exu_wdata;
        next_pc_d  = jump_valid ? jump_target : pc_q + ADDR_WIDTH'(4);
        state_d    = StWb;
      end
      StWb: begin
        pc_d    = next_pc_q;
        state_d = StFetchReq;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StBoot;
      pc_q        <= RESET_PC;
      next_pc_q   <= RESET_PC;
      inst_q      <= '0;
      cnt_q       <= '0;
      wb_wen_q    <= 1'b0;
      wb_waddr_q  <= '0;
      wb_wdata_q  <= '0;
      halt_code_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      next_pc_q   <= next_pc_d;
      inst_q      <= inst_d;
      cnt_q       <= cnt_d;
      wb_wen_q    <= wb_wen_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_wdata_q  <= wb_wdata_d;
      halt_code_q <= halt_code_d;
    end
  end

  assign ifu_req_valid = (state_q == StFetchReq);
  assign pc            = pc_q;
  assign inst          = inst_q;
  assign rf_wen        = (state_q == StWb) & wb_wen_q;
  assign rf_waddr      = wb_waddr_q;
  assign rf_wdata      = wb_wdata_q;
  assign halt          = (state_q == StHalt);
  assign halt_code     = halt_code_q;
  assign busy          = (state_q != StHalt);

`ifdef EXU_SEQ_PERF_CNT_EN
  logic [63:0] perf_cycle_q, perf_retire_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycle_q  <= '0;
      perf_retire_q <= '0;
    end else begin
      if (state_q != StHalt) perf_cycle_q <= perf_cycle_q + 64'd1;
      if (state_q == StWb)   perf_retire_q <= perf_retire_q + 64'd1;
    end
  end

  assign perf_cycle  = perf_cycle_q;
  assign perf_retire = perf_retire_q;
`endif

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// Self-checking bench for exu_seq_ctrl: vector table of instructions plus
// hand-written halt, timeout and reset sequences; register writes are scoreboarded.
module tb_exu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid;
  logic        ifu_req_ready = 1'b0;
  logic        ifu_rsp_valid = 1'b0;
  logic [31:0] ifu_inst = '0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        idu_illegal = 1'b0;
  logic        idu_ebreak = 1'b0;
  logic        exu_wen = 1'b0;
  logic [4:0]  exu_waddr = '0;
  logic [31:0] exu_wdata = '0;
  logic        jump_valid = 1'b0;
  logic [31:0] jump_target = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        halt;
  logic [1:0]  halt_code;
  logic        busy;
`ifdef EXU_SEQ_PERF_CNT_EN
  logic [63:0] perf_cycle;
  logic [63:0] perf_retire;
`endif

  exu_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_inst      (ifu_inst),
    .pc            (pc),
    .inst          (inst),
    .idu_illegal   (idu_illegal),
    .idu_ebreak    (idu_ebreak),
    .exu_wen       (exu_wen),
    .exu_waddr     (exu_waddr),
    .exu_wdata     (exu_wdata),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .rf_wen        (rf_wen),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .halt          (halt),
    .halt_code     (halt_code),
`ifdef EXU_SEQ_PERF_CNT_EN
    .perf_cycle    (perf_cycle),
    .perf_retire   (perf_retire),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    int          ready_dly;
    int          rsp_dly;
    logic        illegal;
    logic        ebreak;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        jump;
    logic [31:0] target;
    logic [1:0]  code;
  } vec_t;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wr_t;

  wr_t         sb[$];
  vec_t        vecs[8];
  vec_t        v_ill;
  int          total = 0;
  int          bad = 0;
  int          last_wait;
  logic [31:0] exp_pc;
  logic [31:0] frozen_pc;
  logic [31:0] frozen_inst;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    wr_t e;
    @(posedge clk);
    #1;
    if (rf_wen === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got waddr=%0d wdata=%0h expected no write",
                 rf_waddr, rf_wdata);
      end else begin
        e = sb.pop_front();
        check("rf_waddr", rf_waddr, e.waddr);
        check("rf_wdata", rf_wdata, e.wdata);
      end
    end
  endtask

  task automatic clear_inputs();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    ifu_inst      = '0;
    idu_illegal   = 1'b0;
    idu_ebreak    = 1'b0;
    exu_wen       = 1'b0;
    exu_waddr     = '0;
    exu_wdata     = '0;
    jump_valid    = 1'b0;
    jump_target   = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    step();
    step();
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_inst", inst, 32'h0);
    check("rst_rf_wen", rf_wen, 1'b0);
    check("rst_req_valid", ifu_req_valid, 1'b0);
    check("rst_halt", {halt, halt_code}, 3'b000);
    check("rst_busy", busy, 1'b1);
    sb.delete();
    exp_pc = 32'h8000_0000;
    rst = 1'b1;
  endtask

  task automatic run_inst(input vec_t v);
    wr_t w;
    int  n;
    n = 0;
    while (ifu_req_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    last_wait = n;
    check("req_valid_seen", ifu_req_valid, 1'b1);
    if (ifu_req_valid !== 1'b1) return;
    check("req_pc", pc, exp_pc);
    // Responses presented before the request is accepted must be ignored.
    ifu_rsp_valid = 1'b1;
    ifu_inst      = 32'hdead_beef;
    for (int i = 0; i < v.ready_dly; i++) begin
      step();
      check("req_held", ifu_req_valid, 1'b1);
    end
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b0;
    check("req_dropped", ifu_req_valid, 1'b0);
    for (int i = 0; i < v.rsp_dly; i++) step();
    ifu_rsp_valid = 1'b1;
    ifu_inst      = v.inst;
    step();
    ifu_rsp_valid = 1'b0;
    ifu_inst      = '0;
    check("inst_latched", inst, v.inst);
    check("no_halt_decode", halt, 1'b0);
    idu_illegal = v.illegal;
    idu_ebreak  = v.ebreak;
    step();
    idu_illegal = 1'b0;
    idu_ebreak  = 1'b0;
    if (v.code != 2'd0) begin
      check("halt", halt, 1'b1);
      check("halt_code", halt_code, v.code);
      check("busy_halted", busy, 1'b0);
      return;
    end
    exu_wen     = v.wen;
    exu_waddr   = v.waddr;
    exu_wdata   = v.wdata;
    jump_valid  = v.jump;
    jump_target = v.target;
    if (v.wen && v.waddr != 5'd0) begin
      w.waddr = v.waddr;
      w.wdata = v.wdata;
      sb.push_back(w);
    end
    step();
    clear_inputs();
    check("pc_stable_wb", pc, exp_pc);
    check("inst_stable_wb", inst, v.inst);
    exp_pc = v.jump ? v.target : exp_pc + 32'd4;
    step();
    check("pc_next", pc, exp_pc);
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{32'h0010_0093, 0, 0,   1'b0, 1'b0, 1'b1, 5'd1,  32'h1,         1'b0, 32'h0,         2'd0};
    vecs[1] = '{32'h0000_0013, 0, 0,   1'b0, 1'b0, 1'b1, 5'd0,  32'h55,        1'b0, 32'h0,         2'd0};
    vecs[2] = '{32'h01f0_0f93, 2, 3,   1'b0, 1'b0, 1'b1, 5'd31, 32'ha5a5_a5a5, 1'b0, 32'h0,         2'd0};
    vecs[3] = '{32'h0050_0293, 0, 1,   1'b0, 1'b0, 1'b0, 5'd5,  32'h1234_5678, 1'b0, 32'h0,         2'd0};
    vecs[4] = '{32'h1000_006f, 1, 0,   1'b0, 1'b0, 1'b1, 5'd2,  32'h1234,      1'b1, 32'h8000_0100, 2'd0};
    vecs[5] = '{32'h0000_0013, 0, 255, 1'b0, 1'b0, 1'b1, 5'd7,  32'hcafe_f00d, 1'b1, 32'hffff_fffc, 2'd0};
    vecs[6] = '{32'h0000_0013, 0, 0,   1'b0, 1'b0, 1'b1, 5'd8,  32'h8,         1'b0, 32'h0,         2'd0};
    vecs[7] = '{32'h0010_0073, 0, 0,   1'b0, 1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 32'h0,         2'd1};
    v_ill   = '{32'hffff_ffff, 0, 0,   1'b1, 1'b1, 1'b1, 5'd3,  32'h3,         1'b0, 32'h0,         2'd2};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      run_inst(vecs[i]);
      if (i == 0) check("boot_cycles", last_wait, 1);
    end

    // Halted core ignores further responses.
    frozen_pc   = exp_pc;
    frozen_inst = vecs[7].inst;
    for (int i = 0; i < 4; i++) begin
      ifu_rsp_valid = 1'b1;
      ifu_inst      = 32'h1111_0000 + i;
      step();
      check("halt_pc_frozen", pc, frozen_pc);
      check("halt_inst_frozen", inst, frozen_inst);
      check("halt_no_req", ifu_req_valid, 1'b0);
      check("halt_sticky", {halt, halt_code}, 3'b101);
    end
    clear_inputs();

    // Illegal has priority over ebreak.
    do_reset();
    run_inst(v_ill);

    // Fetch timeout: 255 idle wait cycles survive, the 256th halts.
    do_reset();
    step();
    check("to_req", ifu_req_valid, 1'b1);
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    repeat (255) step();
    check("to_not_yet", halt, 1'b0);
    step();
    check("to_halt", halt, 1'b1);
    check("to_code", halt_code, 2'd3);
    check("to_busy", busy, 1'b0);

    // Asynchronous reset during EXEC drops the pending write.
    do_reset();
    run_inst(vecs[0]);
    step();
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_inst      = 32'h0030_0193;
    step();
    clear_inputs();
    step();
    exu_wen   = 1'b1;
    exu_waddr = 5'd3;
    exu_wdata = 32'h77;
    #2;
    rst = 1'b0;
    #1;
    check("async_pc", pc, 32'h8000_0000);
    check("async_inst", inst, 32'h0);
    check("async_rf_wen", rf_wen, 1'b0);
    check("async_req", ifu_req_valid, 1'b0);
    step();
    step();
    clear_inputs();
    rst    = 1'b1;
    exp_pc = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      run_inst(vecs[i]);
      if (i == 0) check("resume_boot", last_wait, 1);
    end
`ifdef EXU_SEQ_PERF_CNT_EN
    check("perf_retire", perf_retire, 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exu_seq_ctrl.md
Name: exu_seq_ctrl

Overview:
- Multi-cycle sequencer for the single-issue core: owns the PC and sequences fetch -> decode -> execute -> writeback around the combinational EXU.
- Registers the EXU write request and drives the register-file write port exactly once per retired instruction.
- Halts on ebreak, illegal instruction or fetch timeout.

Parameters:
- ADDR_WIDTH, 32, PC/address width.
- DATA_WIDTH, 32, register-file data width.
- RESET_PC, 32'h8000_0000, PC value after reset.
- TIMEOUT, 255, maximum FETCH_WAIT cycles before halting; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ifu_req_valid  out  1  fetch request for address pc.
- ifu_req_ready  in  1  IFU accepts the request.
- ifu_rsp_valid  in  1  instruction word available.
- ifu_inst  in  32  fetched instruction.
- pc  out  ADDR_WIDTH  current PC.
- inst  out  32  latched instruction for the IDU.
- idu_illegal  in  1  decode error, sampled in DECODE.
- idu_ebreak  in  1  ebreak decoded, sampled in DECODE.
- exu_wen  in  1  EXU write enable.
- exu_waddr  in  5  EXU destination register.
- exu_wdata  in  DATA_WIDTH  EXU result.
- jump_valid  in  1  redirect the PC at retire, sampled in EXEC.
- jump_target  in  ADDR_WIDTH  redirect address.
- rf_wen  out  1  register-file write strobe.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- halt  out  1  core stopped (sticky).
- halt_code  out  2  halt cause: 1 ebreak, 2 illegal, 3 timeout; 0 while running.
- busy  out  1  high in any state other than HALT.

Behaviour:
- Reset values (while rst=0): state=BOOT, pc=RESET_PC, inst=0, rf_wen=0, rf_waddr=0, rf_wdata=0, halt=0, halt_code=0, timeout counter=0, ifu_req_valid=0.
- BOOT: one idle cycle after reset release, then FETCH_REQ.
- FETCH_REQ: ifu_req_valid=1; stays until ifu_req_ready=1, then FETCH_WAIT. ifu_req_valid is not dropped before acceptance.
- FETCH_WAIT: counter increments each cycle.
  - If ifu_rsp_valid=1: inst<=ifu_inst, counter<=0, next DECODE. The response wins if it arrives in the same cycle the counter reaches TIMEOUT.
  - Else if counter==TIMEOUT: HALT with halt_code=3.
  - A response is accepted in the cycle after the request is accepted or later; a response asserted in FETCH_REQ is ignored.
- DECODE: exactly 1 cycle.
  - idu_illegal=1: HALT, code 2. Illegal has priority over ebreak.
  - Else idu_ebreak=1: HALT, code 1.
  - Else: EXEC.
- EXEC: exactly 1 cycle.
  - Registers wb_wen = exu_wen & (exu_waddr!=0), exu_waddr and exu_wdata.
  - Captures next_pc = jump_valid ? jump_target : pc+4. Addition wraps modulo 2^ADDR_WIDTH.
  - Next state WB.
- WB: exactly 1 cycle.
  - rf_wen=wb_wen for this cycle only; rf_waddr and rf_wdata hold the captured values.
  - pc<=next_pc; next state FETCH_REQ.
- rf_wen is 0 in every state except WB. A write to x0 never produces a strobe.
- HALT: absorbing. halt=1, busy=0, pc and inst frozen, all requests 0. Only reset leaves HALT.
- Latency: instruction retire = 5 cycles + IFU handshake delays (FETCH_REQ 1, FETCH_WAIT 1, DECODE, EXEC, WB with zero-wait IFU).
- Reset mid-operation: async return to BOOT with reset values; any pending WB write is dropped.
- inst and pc are stable from DECODE through WB.

Optional Feature:
- Macro EXU_SEQ_PERF_CNT_EN.
- Defined: adds outputs perf_cycle (64) and perf_retire (64), both reset to 0.
  - perf_cycle increments every cycle while not halted.
  - perf_retire increments in each WB cycle.
  - Both wrap at 2^64 and freeze in HALT.
- Undefined: no ports, no counter logic; all other behaviour identical.

Test Plan:
- Reset release, IFU ready=1, response next cycle with inst=32'h00100093, exu_wen=1, waddr=1, wdata=1 -> WB strobe rf_wen=1, rf_waddr=1, rf_wdata=1 on cycle 5 after BOOT; pc becomes 32'h8000_0004.
- exu_waddr=0, exu_wen=1 -> rf_wen stays 0 throughout; pc still advances by 4.
- jump_valid=1, jump_target=32'h8000_0100 in EXEC -> pc=32'h8000_0100 after WB; next ifu_req_valid presents that pc.
- idu_ebreak=1 -> halt=1, halt_code=1, busy=0; further ifu_rsp_valid pulses do not change pc or inst.
- idu_illegal=1 and idu_ebreak=1 together -> halt_code=2. Separately, ifu_rsp_valid held low 256 cycles with TIMEOUT=255 -> halt_code=3.
- Assert rst=0 asynchronously during EXEC -> immediate pc=RESET_PC, rf_wen=0, no write strobe; normal fetch resumes after release. With EXU_SEQ_PERF_CNT_EN, perf_retire=3 after three retires.
